// File: rtl/demultiplexer_1_to_p_stream.sv
// 1-to-P streaming demultiplexer.
// Each of the P = 2^N output channels has a one-word holding register and a
// full flag with valid/ready handshaking. The destination comes from the
// command b, or from a round-robin pointer when mode=1. A full channel whose
// consumer takes its word in the same cycle can accept a new word at once.
`timescale 1ns/1ps
module demultiplexer_1_to_p_stream #(
    parameter int W = 8,
    parameter int N = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [W-1:0]          x,
    input  logic [N-1:0]          b,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [(2**N)*W-1:0]   z,
    output logic [(2**N)-1:0]     out_valid,
    input  logic [(2**N)-1:0]     out_ready,
    output logic [N-1:0]          sel
);

    localparam int P = 2**N;

    logic [N-1:0] rr_reg;
    logic [N-1:0] dest;
    logic         in_xfer;

    // The destination follows the mode input in the same cycle. rr keeps
    // its value while mode=0.
    assign dest     = mode ? rr_reg : b;
    assign sel      = dest;
    // Accept if the target is empty, or if it is emptied on this same edge.
    // Only the target channel is considered, so a stalled channel elsewhere
    // does not block other channels.
    assign in_ready = ~out_valid[dest] | out_ready[dest];
    assign in_xfer  = in_valid & in_ready;

    // Round-robin pointer: advances once per accepted word in mode=1 and
    // wraps naturally because P is a power of two. It never skips a stalled
    // channel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_reg <= '0;
        end else if (in_xfer && mode) begin
            rr_reg <= rr_reg + N'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_chan
            localparam logic [N-1:0] CH = N'(gi);
            logic [W-1:0] data_reg;
            logic         full_reg;
            logic         load;

            assign load = in_xfer && (dest == CH);

            // Holding register and full flag. A load takes priority over a
            // drain on the same edge, so the new word replaces the old one
            // and the flag stays set.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                    full_reg <= 1'b0;
                end else if (load) begin
                    data_reg <= x;
                    full_reg <= 1'b1;
                end else if (full_reg && out_ready[gi]) begin
                    full_reg <= 1'b0;
                end
            end

            assign out_valid[gi]     = full_reg;
            // An empty channel drives zeros, as a combinational demux would.
            assign z[gi*W +: W]      = full_reg ? data_reg : '0;
        end
    endgenerate

endmodule

// File: tb/tb_demultiplexer_1_to_p_stream.sv
// Self-checking bench for demultiplexer_1_to_p_stream (W=8, N=2).
`timescale 1ns/1ps
module tb_demultiplexer_1_to_p_stream;

    localparam int W = 8;
    localparam int N = 2;
    localparam int P = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [W-1:0]     x;
    logic [N-1:0]     b;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [P*W-1:0]   z;
    logic [P-1:0]     out_valid;
    logic [P-1:0]     out_ready;
    logic [N-1:0]     sel;

    demultiplexer_1_to_p_stream #(.W(W), .N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .b         (b),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: channel contents as plain arrays plus a pointer.
    bit           m_full [P];
    logic [W-1:0] m_data [P];
    int           m_rr;

    typedef struct {
        logic         mode;
        logic [N-1:0] b;
        logic [W-1:0] x;
        logic         v;
        logic [P-1:0] ordy;
        logic         e_rdy;
        logic [P-1:0] e_ov;
        logic [P*W-1:0] e_z;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < P; p++) begin
            m_full[p] = 1'b0;
            m_data[p] = '0;
        end
        m_rr = 0;
    endtask

    function automatic logic [P-1:0] model_ov();
        logic [P-1:0] r;
        r = '0;
        for (int p = 0; p < P; p++) r[p] = m_full[p];
        return r;
    endfunction

    function automatic logic [P*W-1:0] model_z();
        logic [P*W-1:0] r;
        r = '0;
        for (int p = 0; p < P; p++) if (m_full[p]) r[p*W +: W] = m_data[p];
        return r;
    endfunction

    // One clock: called at posedge+1 with inputs already driven. Checks the
    // combinational outputs at the negedge and the registered ones after the edge.
    task automatic cycle(output logic r_got, output logic [N-1:0] sel_got,
                         output logic [P-1:0] ov_got, output logic [P*W-1:0] z_got);
        int   d;
        logic er;
        logic xfer;
        @(negedge clock);
        d  = mode ? m_rr : int'(b);
        er = !m_full[d] || out_ready[d];
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("sel", 64'(sel), 64'(d));
        r_got   = in_ready;
        sel_got = sel;
        @(posedge clock);
        xfer = in_valid && er;
        // Consumers take their words first, then the accepted word lands.
        for (int p = 0; p < P; p++) if (out_ready[p]) m_full[p] = 1'b0;
        if (xfer) begin
            m_full[d] = 1'b1;
            m_data[d] = x;
            if (mode) m_rr = (m_rr + 1) % P;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(model_ov()));
        chk("z", 64'(z), 64'(model_z()));
        ov_got = out_valid;
        z_got  = z;
        $display("cyc mode=%0d b=%0d x=%02h v=%0d ordy=%b rdy=%0d sel=%0d ov=%b z=%08h",
                 mode, b, x, in_valid, out_ready, r_got, sel_got, ov_got, z_got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic           r;
        logic [N-1:0]   s;
        logic [P-1:0]   ov;
        logic [P*W-1:0] zz;
        int             exp_ch [5];

        // Directed sequence starting from empty channels, mode=0.
        tbl[0] = '{1'b0, 2'd2, 8'hA5, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000};
        tbl[1] = '{1'b0, 2'd2, 8'h5A, 1'b1, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000};
        tbl[2] = '{1'b0, 2'd1, 8'h3C, 1'b1, 4'b0000, 1'b1, 4'b0110, 32'h00A5_3C00};
        tbl[3] = '{1'b0, 2'd3, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b1110, 32'h11A5_3C00};
        tbl[4] = '{1'b0, 2'd3, 8'h22, 1'b1, 4'b1000, 1'b1, 4'b1110, 32'h22A5_3C00};
        tbl[5] = '{1'b0, 2'd0, 8'hFF, 1'b0, 4'b0110, 1'b1, 4'b1000, 32'h2200_0000};
        tbl[6] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1000, 1'b1, 4'b0000, 32'h0000_0000};

        reset = 1'b1; mode = 1'b0; b = 2'd2; x = '0; in_valid = 1'b0; out_ready = '0;
        model_reset();
        #1;
        chk("rst_ov", 64'(out_valid), 64'(0));
        chk("rst_z", 64'(z), 64'(0));
        chk("rst_sel_m0", 64'(sel), 64'(2));
        mode = 1'b1;
        #1;
        chk("rst_sel_m1", 64'(sel), 64'(0));
        mode = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            mode = tbl[i].mode; b = tbl[i].b; x = tbl[i].x;
            in_valid = tbl[i].v; out_ready = tbl[i].ordy;
            cycle(r, s, ov, zz);
            chk($sformatf("tbl%0d_rdy", i), 64'(r), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_ov", i), 64'(ov), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_z", i), 64'(zz), 64'(tbl[i].e_z));
        end

        // Round-robin with all consumers ready: channels 0,1,2,3,0.
        exp_ch = '{0, 1, 2, 3, 0};
        mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = W'(i + 1);
            cycle(r, s, ov, zz);
            chk("rr_sel", 64'(s), 64'(exp_ch[i]));
            chk("rr_ov", 64'(ov), 64'(1 << exp_ch[i]));
            chk("rr_word", 64'(zz[exp_ch[i]*W +: W]), 64'(i + 1));
        end
        in_valid = 1'b0;
        #1 chk("rr_wrap_sel", 64'(sel), 64'(1));

        // Fill channel 1 via command, then stall round-robin on it.
        mode = 1'b0; b = 2'd1; x = 8'h44; in_valid = 1'b1; out_ready = '0;
        cycle(r, s, ov, zz);
        mode = 1'b1; x = 8'h55;
        for (int i = 0; i < 3; i++) begin
            cycle(r, s, ov, zz);
            chk("stall_rdy", 64'(r), 64'(0));
            chk("stall_sel", 64'(s), 64'(1));
            chk("stall_word", 64'(zz[W +: W]), 64'(8'h44));
        end
        out_ready = 4'b0010;
        cycle(r, s, ov, zz);
        chk("release_rdy", 64'(r), 64'(1));
        chk("release_ov1", 64'(ov[1]), 64'(1));
        chk("release_word", 64'(zz[W +: W]), 64'(8'h55));
        in_valid = 1'b0;
        #1 chk("release_sel", 64'(sel), 64'(2));

        // Channels 0 and 2 full with rr=3, then asynchronous reset.
        out_ready = 4'b1111; mode = 1'b0;
        cycle(r, s, ov, zz);
        mode = 1'b1; x = 8'hAB; in_valid = 1'b1; out_ready = '0;
        cycle(r, s, ov, zz);
        mode = 1'b0; b = 2'd0; x = 8'hCD;
        cycle(r, s, ov, zz);
        mode = 1'b1; in_valid = 1'b0;
        #1;
        chk("pre_rst_sel", 64'(sel), 64'(3));
        chk("pre_rst_ov", 64'(out_valid), 64'(4'b0101));
        @(negedge clock);
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("async_ov", 64'(out_valid), 64'(0));
        chk("async_z", 64'(z), 64'(0));
        chk("async_sel", 64'(sel), 64'(0));
        mode = 1'b0; b = 2'd0; x = 8'hE1; in_valid = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_edge_ov", 64'(out_valid), 64'(0));
        reset = 1'b0;
        cycle(r, s, ov, zz);
        chk("post_rst_ov", 64'(ov), 64'(4'b0001));
        chk("post_rst_word", 64'(zz[0 +: W]), 64'(8'hE1));

        // Randomised traffic against the model.
        repeat (400) begin
            mode      = 1'($urandom_range(0, 1));
            b         = N'($urandom);
            x         = W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = P'($urandom);
            cycle(r, s, ov, zz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
